pio_input_debounce: RTL and testbench
=====================================

// Module: pio_input_debounce
// PURPOSE
//  Conditions raw board inputs (push-buttons, slide switches) before they reach the
//  edge-capturing PIO input port. It provides per-bit 2-FF synchronisation and
//  tick-based stability filtering, so the PIO edge_capture sees exactly one edge per
//  physical press/release. It sits between top-level pins and the PIO in_port.
// PARAMETERS
//  WIDTH         8       number of independent input bits
//  TICK_DIV      50000   clk cycles per sampling tick (1 ms @ 50 MHz); >= 2
//  STABLE_TICKS  10      consecutive ticks a new level must persist before acceptance; >= 1
//  CNT_W         4       width of per-bit tick counter; 2**CNT_W > STABLE_TICKS
//  RESET_VAL     8'hFF   clean_out value after reset (active-low keys idle high)
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      synchronous reset, active low
//  raw_in     in   WIDTH  asynchronous pin inputs
//  clean_out  out  WIDTH  debounced level, drives PIO in_port
//  tick       out  1      prescaler strobe, one clk wide (debug/observability)
// BEHAVIOUR
//  - Reset (reset_n=0 sampled at posedge clk): clean_out=RESET_VAL, sync FFs=RESET_VAL,
//    prescaler=0, all bit counters=0, tick=0. A reset during filtering abandons the
//    pending change.
//  - Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where count==TICK_DIV-1.
//  - Sync: s1<=raw_in; s2<=s1. Only s2 is used downstream.
//  - Per bit i, two states:
//    * IDLE (s2[i]==clean_out[i]): cnt=0.
//    * PEND (s2[i]!=clean_out[i]): on tick, cnt++. On a tick with cnt==STABLE_TICKS-1,
//      set clean_out[i]<=s2[i] and cnt<=0.
//  - Any cycle where s2[i] returns to clean_out[i] clears cnt in that same cycle (glitch
//    rejected); tick in that cycle does not increment.
//  - Latency from stable raw change to clean_out change: 2 + (STABLE_TICKS-1)*TICK_DIV + 1
//    to 2 + STABLE_TICKS*TICK_DIV cycles, depending on tick phase.
//  - Bits are fully independent; simultaneous changes on several bits may update on the
//    same tick.
//  - The counter never exceeds STABLE_TICKS-1, so no wrap-around is possible.
// CONFIGURATION
//  PIO_DEBOUNCE_EDGE_EN defined: adds outputs rise_pulse[WIDTH] and fall_pulse[WIDTH].
//    Each is one clk wide, registered, and asserted the cycle after clean_out[i] goes
//    0->1 or 1->0. Both reset to 0.
//  PIO_DEBOUNCE_EDGE_EN undefined: these ports and their registers do not exist; the
//    port list is exactly as listed above.
// STRUCTURE
//  - Shared package pio_debounce_pkg: default constants (TICK_DIV_1MS_50MHZ=50000,
//    STABLE_TICKS_DEF=10, KEY_IDLE_VAL=8'hFF) and a clog2 function for CNT_W derivation.
//  - Sub-module debounce_bit: per-bit IDLE/PEND filter (inputs clk, reset_n, tick, s2 bit;
//    output clean bit). Generate loop instantiates WIDTH copies.
//  - Prescaler and synchroniser live in the top module.
// TESTING (bench params WIDTH=8, TICK_DIV=4, STABLE_TICKS=3, RESET_VAL=8'hFF)
//  1. Reset held 3 cycles with raw_in=8'h00: clean_out=8'hFF and tick=0 throughout reset;
//     first tick 4 cycles after release.
//  2. raw_in[0] 1->0 held: clean_out=8'hFE after 11..14 cycles, never earlier.
//  3. raw_in[1] pulses low 5 cycles, then returns high: clean_out stays 8'hFF; counter
//     cleared.
//  4. raw_in[0] and raw_in[7] fall in the same cycle: clean_out goes 8'hFF->8'h7E in a
//     single cycle.
//  5. Reset asserted mid-PEND (cnt=2): clean_out=RESET_VAL; after release, full
//     STABLE_TICKS are required again.
//  6. With PIO_DEBOUNCE_EDGE_EN, bit 2 press then release: fall_pulse=8'h04 and later
//     rise_pulse=8'h04, each exactly 1 cycle.

Source files
------------

// File: rtl/pio_debounce_pkg.sv
// Shared constants and helpers for the PIO input debouncer.
package pio_debounce_pkg;

    localparam int unsigned TICK_DIV_1MS_50MHZ = 50000;
    localparam int unsigned STABLE_TICKS_DEF   = 10;
    localparam logic [7:0]  KEY_IDLE_VAL       = 8'hFF;

    typedef enum logic {
        DB_IDLE = 1'b0,
        DB_PEND = 1'b1
    } db_state_e;

    // Smallest n such that 2**n >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_input_debounce_bit.sv
// Single-bit stability filter: accepts a new level after STABLE_TICKS consecutive ticks.
module debounce_bit
    import pio_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int unsigned CNT_W        = 4,
    parameter logic        RESET_VAL    = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic sync_bit,
    output logic clean
);

    db_state_e          state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               clean_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt   <= '0;
            clean <= RESET_VAL;
        end else begin
            cnt   <= cnt_n;
            clean <= clean_n;
        end
    end

    // State is decoded from the level mismatch, so a glitch back clears cnt immediately.
    always_comb begin
        state   = (sync_bit == clean) ? DB_IDLE : DB_PEND;
        cnt_n   = cnt;
        clean_n = clean;
        case (state)
            DB_IDLE: cnt_n = '0;
            DB_PEND: begin
                if (tick) begin
                    if (cnt == CNT_W'(STABLE_TICKS - 1)) begin
                        clean_n = sync_bit;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: cnt_n = '0;
        endcase
    end

endmodule

// File: rtl/pio_input_debounce.sv
// Input conditioner for PIO in_port: 2-FF sync, tick prescaler, per-bit debounce.
// Optional PIO_DEBOUNCE_EDGE_EN adds registered rise_pulse/fall_pulse outputs.
module pio_input_debounce
    import pio_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      TICK_DIV     = TICK_DIV_1MS_50MHZ,
    parameter int unsigned      STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int unsigned      CNT_W        = clog2(STABLE_TICKS + 1),
    parameter logic [WIDTH-1:0] RESET_VAL    = WIDTH'(KEY_IDLE_VAL)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic             tick
`ifdef PIO_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`endif
);

    localparam int unsigned PW = clog2(TICK_DIV);

    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] clean;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
        end else if (presc == PW'(TICK_DIV - 1)) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .CNT_W        (CNT_W),
            .RESET_VAL    (RESET_VAL[i])
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick),
            .sync_bit (s2[i]),
            .clean    (clean[i])
        );
    end

    assign clean_out = clean;

`ifdef PIO_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] clean_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clean_d    <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            clean_d    <= clean;
            rise_pulse <= clean & ~clean_d;
            fall_pulse <= ~clean & clean_d;
        end
    end
`endif

endmodule

// File: tb/tb_pio_input_debounce.sv
// Randomised bench for pio_input_debounce with a behavioural per-bit stability model.
module tb_pio_input_debounce;

    localparam int unsigned W  = 8;
    localparam int unsigned TD = 4;
    localparam int unsigned ST = 3;
    localparam logic [W-1:0] RV = 8'hFF;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] clean_out;
    logic         tick;
`ifdef PIO_DEBOUNCE_EDGE_EN
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;
`endif

    int checks = 0;
    int errors = 0;

    pio_input_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .CNT_W        (2),
        .RESET_VAL    (RV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .raw_in    (raw_in),
        .clean_out (clean_out),
        .tick      (tick)
`ifdef PIO_DEBOUNCE_EDGE_EN
        ,
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles since reset give the tick phase; each bit counts ticks seen while
    // its delayed input has disagreed with the accepted level without interruption.
    int           m_cyc;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_s1, m_s2, m_clean, m_cprev, m_rise, m_fall;
    int           m_ticks [W];

    always @(posedge clk) begin : model
        logic [W-1:0] nc;
        bit           tk;
        int           nt;
        if (!reset_n) begin
            m_s1    <= RV;
            m_s2    <= RV;
            m_clean <= RV;
            m_cprev <= RV;
            m_rise  <= '0;
            m_fall  <= '0;
            m_cyc   <= 0;
            for (int i = 0; i < W; i++) m_ticks[i] <= 0;
            m_valid <= 1'b1;
        end else begin
            tk = (m_cyc % TD) == TD - 1;
            nc = m_clean;
            for (int i = 0; i < W; i++) begin
                nt = m_ticks[i];
                if (m_s2[i] == m_clean[i]) nt = 0;
                else if (tk) begin
                    nt = nt + 1;
                    if (nt == ST) begin
                        nc[i] = m_s2[i];
                        nt    = 0;
                    end
                end
                m_ticks[i] <= nt;
            end
            m_clean <= nc;
            m_rise  <= m_clean & ~m_cprev;
            m_fall  <= ~m_clean & m_cprev;
            m_cprev <= m_clean;
            m_s2    <= m_s1;
            m_s1    <= raw_in;
            m_cyc   <= m_cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("clean_out", 64'(clean_out), 64'(m_clean));
            chk("tick", 64'(tick), 64'((m_cyc % TD) == TD - 1));
`ifdef PIO_DEBOUNCE_EDGE_EN
            chk("rise_pulse", 64'(rise_pulse), 64'(m_rise));
            chk("fall_pulse", 64'(fall_pulse), 64'(m_fall));
`endif
        end
    end

    task automatic wait_clean(input logic [W-1:0] exp, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clean_out !== exp && n < limit);
        if (clean_out !== exp) begin
            checks++;
            errors++;
            $display("FAIL wait_clean timeout actual=%0h expected=%0h", clean_out, exp);
        end
    endtask

    initial begin
        int n;
        int first;
        bit bad;
        reset_n = 1'b0;
        raw_in  = 8'h00;

        // Reset held 3 cycles, then first tick on the 4th cycle counted from reset exit.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_clean", 64'(clean_out), 64'(8'hFF));
            chk("reset_tick", 64'(tick), 64'(0));
        end
        raw_in  = 8'hFF;
        reset_n = 1'b1;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            if (tick && first == 0) first = k;
            @(negedge clk);
        end
        chk("first_tick_cycle", 64'(first), 64'(4));

        // Single-bit press: latency must fall in the 11..14 window.
        raw_in = 8'hFE;
        wait_clean(8'hFE, 30, n);
        chk("press_latency_ok", 64'(n >= 11 && n <= 14), 64'(1));
        raw_in = 8'hFF;
        wait_clean(8'hFF, 30, n);

        // Short glitch on bit 1 must be rejected.
        raw_in = 8'hFD;
        repeat (5) @(negedge clk);
        raw_in = 8'hFF;
        repeat (20) @(negedge clk);
        chk("glitch_rejected", 64'(clean_out), 64'(8'hFF));

        // Two bits falling together update in the same cycle.
        raw_in = 8'h7E;
        bad = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (clean_out !== 8'hFF && clean_out !== 8'h7E) bad = 1'b1;
        end while (clean_out !== 8'h7E && n < 30);
        chk("dual_no_partial", 64'(bad), 64'(0));
        chk("dual_final", 64'(clean_out), 64'(8'h7E));
        raw_in = 8'hFF;
        wait_clean(8'hFF, 30, n);

        // Reset mid-pending (two ticks counted) forces a full restart of filtering.
        raw_in = 8'hF7;
        repeat (10) @(negedge clk);
        chk("pending_not_yet", 64'(clean_out), 64'(8'hFF));
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mid_pend", 64'(clean_out), 64'(8'hFF));
        reset_n = 1'b1;
        wait_clean(8'hF7, 30, n);
        chk("restart_latency", 64'(n), 64'(12));
        raw_in = 8'hFF;
        wait_clean(8'hFF, 30, n);

`ifdef PIO_DEBOUNCE_EDGE_EN
        raw_in = 8'hFB;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fall_pulse === '0 && n < 30);
        chk("fall_pulse_val", 64'(fall_pulse), 64'(8'h04));
        @(negedge clk);
        chk("fall_pulse_1cyc", 64'(fall_pulse), 64'(0));
        raw_in = 8'hFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rise_pulse === '0 && n < 30);
        chk("rise_pulse_val", 64'(rise_pulse), 64'(8'h04));
        @(negedge clk);
        chk("rise_pulse_1cyc", 64'(rise_pulse), 64'(0));
`endif

        // Random phase: alternating fast-glitch and slow-change blocks, rare resets.
        for (int blk = 0; blk < 16; blk++) begin
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                reset_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
                for (int b = 0; b < W; b++) begin
                    if ($urandom_range(0, (blk % 2 == 0) ? 7 : 40) == 0)
                        raw_in[b] = ~raw_in[b];
                end
            end
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
